regport_arbiter: RTL

REGPORT_ARBITER -- requirements
Module: regport_arbiter

---
 rtl/regport_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/regport_arbiter.sv
// Shares one register-file read port among four requesters: one grant per cycle,
// response one cycle later. Define REGARB_RR_EN for round-robin; default is fixed priority.
module regport_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] req_regid,
  input  logic        stall,
  input  logic [15:0] rd_data_in,
  output logic [3:0]  rd_regid,
  output logic [3:0]  grant,
  output logic [3:0]  rsp_valid,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        dbg_state
);

  // Handshake: req[i] is a level request with no ready; it is consumed at the
  // edge where grant[i] is high, and a still-high req after that is a new request.
  // rsp_valid[i] is a one-cycle strobe with no back-pressure.

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t     state, next_state;
  logic [1:0] start_idx;
  logic [1:0] scan_idx;
  logic [1:0] win_idx;
  logic       win_found;
  logic [3:0] grant_d;
  logic [3:0] regid_d;

`ifdef REGARB_RR_EN
  logic [1:0] rr_ptr;

  // Pointer holds the last winner; reset value 3 makes requester 0 first in line.
  assign start_idx = rr_ptr + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd3;
    end else if (next_state == ISSUE) begin
      rr_ptr <= win_idx;
    end
  end
`else
  assign start_idx = 2'd0;
`endif

  always_comb begin
    win_idx   = 2'd0;
    win_found = 1'b0;
    scan_idx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = start_idx + 2'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    if (!stall && win_found) begin
      next_state = ISSUE;
    end
  end

  always_comb begin
    grant_d = 4'h0;
    regid_d = 4'h0;
    if (next_state == ISSUE) begin
      grant_d[win_idx] = 1'b1;
      regid_d          = req_regid[{win_idx, 2'b00} +: 4];
    end
  end

  assign busy      = (state == ISSUE) || (|rsp_valid);
  assign dbg_state = (state == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= 4'h0;
      rd_regid <= 4'h0;
    end else begin
      grant    <= grant_d;
      rd_regid <= regid_d;
    end
  end

  // Read data is sampled at the end of the ISSUE cycle; R0 always reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 4'h0;
      rsp_data  <= 16'h0000;
    end else begin
      rsp_valid <= (state == ISSUE) ? grant : 4'h0;
      if (state == ISSUE) begin
        rsp_data <= (rd_regid == 4'h0) ? 16'h0000 : rd_data_in;
      end
    end
  end

endmodule
